// File: rtl/exp_bcd_formatter_if.sv
// Result/digit bus between the exponential unit's result and the BCD formatter.
interface exp_bcd_formatter_if #(
  parameter int unsigned FRAC_W = 16,
  parameter int unsigned NDIG   = 4
);
  logic                  in_valid;
  logic [1:0]            intpart;
  logic [FRAC_W-1:0]     fracpart;
  logic                  busy;
  logic                  out_valid;
  logic [3:0]            int_digit;
  logic [4*NDIG-1:0]     frac_digits;

  // Producer side: drives the result strobe, observes the digits.
  modport master (
    output in_valid, intpart, fracpart,
    input  busy, out_valid, int_digit, frac_digits
  );

  // Formatter side.
  modport slave (
    input  in_valid, intpart, fracpart,
    output busy, out_valid, int_digit, frac_digits
  );
endinterface

// File: rtl/exp_bcd_formatter.sv
// Converts a 2.FRAC_W fixed-point result to BCD digits, one truncated fractional
// digit per clock via x10 shift-add. Outputs hold until the next conversion completes.
module exp_bcd_formatter #(
  parameter int unsigned FRAC_W = 16,
  parameter int unsigned NDIG   = 4
) (
  input logic                clk,
  input logic                rst,
  exp_bcd_formatter_if.slave bus
);

  localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NDIG - 1);

  typedef enum logic {StIdle, StConv} state_e;

  state_e              state_q, state_d;
  logic [FRAC_W-1:0]   frac_q, frac_d;
  logic [1:0]          int_q, int_d;
  logic [4*NDIG-1:0]   sr_q, sr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [3:0]          int_digit_q, int_digit_d;
  logic [4*NDIG-1:0]   frac_digits_q, frac_digits_d;

  logic [FRAC_W+3:0]   frac_ext;
  logic [FRAC_W+3:0]   prod;
  logic [3:0]          digit;
  logic [4*NDIG+3:0]   sr_wide;
  logic [4*NDIG-1:0]   sr_shift;

  // x10 datapath; the wide concat keeps the shift legal for NDIG = 1.
  always_comb begin
    frac_ext = {4'b0000, frac_q};
    prod     = (frac_ext << 3) + (frac_ext << 1);
    digit    = prod[FRAC_W+3:FRAC_W];
    sr_wide  = {sr_q, digit};
    sr_shift = sr_wide[4*NDIG-1:0];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d       = state_q;
    frac_d        = frac_q;
    int_d         = int_q;
    sr_d          = sr_q;
    cnt_d         = cnt_q;
    out_valid_d   = 1'b0;
    int_digit_d   = int_digit_q;
    frac_digits_d = frac_digits_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          int_d   = bus.intpart;
          frac_d  = bus.fracpart;
          cnt_d   = '0;
          sr_d    = '0;
          state_d = StConv;
        end
      end
      StConv: begin
        // Strobes arriving here are dropped by design.
        frac_d = prod[FRAC_W-1:0];
        sr_d   = sr_shift;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          frac_digits_d = sr_shift;
          int_digit_d   = {2'b00, int_q};
          out_valid_d   = 1'b1;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      frac_q        <= '0;
      int_q         <= '0;
      sr_q          <= '0;
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      int_digit_q   <= '0;
      frac_digits_q <= '0;
    end else begin
      state_q       <= state_d;
      frac_q        <= frac_d;
      int_q         <= int_d;
      sr_q          <= sr_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      int_digit_q   <= int_digit_d;
      frac_digits_q <= frac_digits_d;
    end
  end

  assign bus.busy        = (state_q == StConv);
  assign bus.out_valid   = out_valid_q;
  assign bus.int_digit   = int_digit_q;
  assign bus.frac_digits = frac_digits_q;

endmodule

// File: tb/tb_exp_bcd_formatter.sv
// Directed bench for exp_bcd_formatter with hand-computed decimal expectations.
module tb_exp_bcd_formatter;

  localparam int unsigned FRAC_W = 16;
  localparam int unsigned NDIG   = 4;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  exp_bcd_formatter_if #(.FRAC_W(FRAC_W), .NDIG(NDIG)) bus ();

  exp_bcd_formatter #(.FRAC_W(FRAC_W), .NDIG(NDIG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a one-cycle strobe captured at the next rising edge, then scramble inputs.
  task automatic strobe(input logic [1:0] ip, input logic [15:0] fp);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.intpart  = ip;
    bus.fracpart = fp;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.intpart  = 2'($urandom);
    bus.fracpart = 16'($urandom);
  endtask

  // Wait (bounded) for out_valid; lat counts edges after capture, bcnt busy samples.
  task automatic wait_done(output logic got, output int lat, output int bcnt);
    got  = 1'b0;
    lat  = 0;
    bcnt = 0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got = 1'b1;
        lat = c;
      end else if (bus.busy) begin
        bcnt++;
      end
    end
  endtask

  task automatic test_reset();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.intpart  = 2'd0;
    bus.fracpart = 16'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.busy, bus.out_valid, bus.int_digit, bus.frac_digits} !== 22'd0)
      $display("FAIL reset_outputs: got busy=%b ov=%b int=%h frac=%h, need all 0",
               bus.busy, bus.out_valid, bus.int_digit, bus.frac_digits);
    else passed++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
      $display("FAIL reset_release_idle: got busy=%b ov=%b, need 0 0", bus.busy, bus.out_valid);
    else passed++;
  endtask

  // Single conversion with latency, busy-length, digits and hold checks.
  task automatic test_convert(input string name, input logic [1:0] ip, input logic [15:0] fp,
                              input logic [3:0] exp_int, input logic [15:0] exp_frac);
    logic got;
    int   lat;
    int   bcnt;
    strobe(ip, fp);
    wait_done(got, lat, bcnt);
    total++;
    if (!got) begin
      $display("FAIL %s_timeout: got no out_valid, need one after %0d cycles", name, NDIG);
      return;
    end else passed++;
    total++;
    if (lat != NDIG) $display("FAIL %s_latency: got %0d, need %0d", name, lat, NDIG);
    else passed++;
    total++;
    if (bcnt != NDIG) $display("FAIL %s_busy_len: got %0d, need %0d", name, bcnt, NDIG);
    else passed++;
    total++;
    if (bus.int_digit !== exp_int || bus.frac_digits !== exp_frac)
      $display("FAIL %s_digits: got %h.%h, need %h.%h", name, bus.int_digit, bus.frac_digits,
               exp_int, exp_frac);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.frac_digits !== exp_frac)
      $display("FAIL %s_hold: got ov=%b busy=%b frac=%h, need 0 0 %h", name, bus.out_valid,
               bus.busy, bus.frac_digits, exp_frac);
    else passed++;
  endtask

  task automatic test_mid_reset();
    logic seen;
    strobe(2'd3, 16'hB7E1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.out_valid, bus.int_digit, bus.frac_digits} !== 22'd0)
      $display("FAIL midreset_outputs: got busy=%b ov=%b int=%h frac=%h, need all 0",
               bus.busy, bus.out_valid, bus.int_digit, bus.frac_digits);
    else passed++;
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy) seen = 1'b1;
    end
    total++;
    if (seen) $display("FAIL midreset_no_ov: got out_valid/busy activity, need none");
    else passed++;
  endtask

  task automatic test_drop();
    logic got;
    logic extra;
    int   lat;
    int   bcnt;
    strobe(2'd1, 16'h8000);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.intpart  = 2'd0;
    bus.fracpart = 16'h4000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_done(got, lat, bcnt);
    total++;
    if (!got || bus.frac_digits !== 16'h5000 || bus.int_digit !== 4'd1)
      $display("FAIL drop_result: got ov=%b %h.%h, need 1 1.5000", got, bus.int_digit,
               bus.frac_digits);
    else passed++;
    extra = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid) extra = 1'b1;
    end
    total++;
    if (extra || bus.frac_digits !== 16'h5000)
      $display("FAIL drop_second: got extra_ov=%b frac=%h, need 0 5000", extra, bus.frac_digits);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic got;
    int   lat;
    int   bcnt;
    strobe(2'd1, 16'h8000);
    wait_done(got, lat, bcnt);
    total++;
    if (!got) $display("FAIL b2b_first: got no out_valid, need one");
    else passed++;
    // Still in the out_valid cycle: this strobe must be accepted.
    bus.in_valid = 1'b1;
    bus.intpart  = 2'd0;
    bus.fracpart = 16'h4000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_done(got, lat, bcnt);
    total++;
    if (!got || lat != NDIG || bus.int_digit !== 4'd0 || bus.frac_digits !== 16'h2500)
      $display("FAIL b2b_second: got ov=%b lat=%0d %h.%h, need 1 %0d 0.2500", got, lat,
               bus.int_digit, bus.frac_digits, NDIG);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_convert("e", 2'd2, 16'hB7E1, 4'd2, 16'h7182);
    test_convert("half", 2'd1, 16'h8000, 4'd1, 16'h5000);
    test_convert("trunc", 2'd1, 16'hFFFF, 4'd1, 16'h9999);
    test_convert("zero", 2'd1, 16'h0000, 4'd1, 16'h0000);
    test_convert("small", 2'd3, 16'h1999, 4'd3, 16'h0999);
    test_mid_reset();
    test_drop();
    test_back_to_back();
    test_convert("eighth", 2'd0, 16'h2000, 4'd0, 16'h1250);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
